// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and byte-enable lookup.
// Lane convention: be[3] / data[31:24] is the lowest byte address (big-endian).
package mem_stage_pkg;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  // Size 2'b11 falls into the word case; low address bits beyond the size are ignored.
  function automatic logic [3:0] be_lookup(input logic [1:0] dsize, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (dsize)
      DSIZE_BYTE: be = 4'b1000 >> addr_lo;
      DSIZE_HALF: be = addr_lo[1] ? 4'b0011 : 4'b1100;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational lane steering: store byte-enables / lane replication and load extraction
// with optional sign extension.
module mem_align_unit
  import mem_stage_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_sign,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be = be_lookup(st_size, st_addr_lo);
    case (st_size)
      DSIZE_BYTE: st_wdata = {4{st_data[7:0]}};
      DSIZE_HALF: st_wdata = {2{st_data[15:0]}};
      default:    st_wdata = st_data;
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'b00:   ld_byte = ld_rdata[31:24];
      2'b01:   ld_byte = ld_rdata[23:16];
      2'b10:   ld_byte = ld_rdata[15:8];
      default: ld_byte = ld_rdata[7:0];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[15:0] : ld_rdata[31:16];
    case (ld_size)
      DSIZE_BYTE: ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
      DSIZE_HALF: ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
      default:    ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory req/ack port, stalls upstream while an access
// is outstanding, and forms write-back fields. Optional MEM_MISALIGN_TRAP_EN traps misaligned access.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        flush,
  input  logic [31:0] next_pc,
  input  logic [31:0] op_b,
  input  logic [4:0]  dest_reg,
  input  logic [31:0] alu_result,
  input  logic        pc_to_reg,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic        mem_write,
  input  logic        load_sign,
  input  logic [1:0]  dsize,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lo_q, lo_d;
  logic        sign_q, sign_d;
  logic [4:0]  dest_q, dest_d;
  logic        rw_q, rw_d;
  logic        kill_q, kill_d;
  logic        err_q, err_d;
  logic [31:0] ldata_q, ldata_d;

  logic        mem_op, live, misalign, trap;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  assign mem_op = mem_to_reg | mem_write;
  assign live   = in_valid & ~flush;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = ((dsize == DSIZE_HALF) & alu_result[0]) |
                    (dsize[1] & (alu_result[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Store side uses the live EX/MEM fields; load side uses the fields latched at issue.
  mem_align_unit u_align (
    .st_size    (dsize),
    .st_addr_lo (alu_result[1:0]),
    .st_data    (op_b),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_size    (size_q),
    .ld_addr_lo (lo_q),
    .ld_sign    (sign_q),
    .ld_rdata   (dmem_rdata),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    lo_d         = lo_q;
    sign_d       = sign_q;
    dest_d       = dest_q;
    rw_d         = rw_q;
    kill_d       = kill_q;
    err_d        = 1'b0;
    ldata_d      = ldata_q;
    trap         = 1'b0;
    stall        = 1'b0;
    wb_valid     = 1'b0;
    wb_reg_write = 1'b0;
    wb_dest      = dest_reg;
    wb_data      = pc_to_reg ? next_pc : alu_result;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!mem_op) begin
          wb_valid     = live;
          wb_reg_write = live & reg_write;
        end else if (live && misalign) begin
          trap = 1'b1;
        end else if (live) begin
          stall   = 1'b1;
          state_d = StWait;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {alu_result[31:2], 2'b00};
          be_d    = st_be;
          wdata_d = st_wdata;
          size_d  = dsize;
          lo_d    = alu_result[1:0];
          sign_d  = load_sign;
          dest_d  = dest_reg;
          rw_d    = reg_write & ~mem_write;
          kill_d  = 1'b0;
        end
      end
      StWait: begin
        stall = 1'b1;
        // A flushed access still runs to completion; only its write-back is suppressed.
        if (flush) kill_d = 1'b1;
        if (dmem_ack) begin
          req_d   = 1'b0;
          ldata_d = ld_data;
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          kill_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        wb_valid     = ~kill_q & ~flush;
        wb_reg_write = ~kill_q & ~flush & rw_q;
        wb_dest      = dest_q;
        wb_data      = ldata_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      lo_q    <= '0;
      sign_q  <= 1'b0;
      dest_q  <= '0;
      rw_q    <= 1'b0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      lo_q    <= lo_d;
      sign_q  <= sign_d;
      dest_q  <= dest_d;
      rw_q    <= rw_d;
      kill_q  <= kill_d;
      err_q   <= err_d;
      ldata_q <= ldata_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign mem_err    = err_q | trap;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases then random ALU/load/store traffic checked
// against an arithmetic model of lane selection, extension, stalls and timeout.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, flush, pc_to_reg, reg_write, mem_to_reg, mem_write, load_sign;
  logic [31:0] next_pc, op_b, alu_result, dmem_rdata;
  logic [4:0]  dest_reg;
  logic [1:0]  dsize;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, stall, wb_valid, wb_reg_write, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_dest;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .flush        (flush),
    .next_pc      (next_pc),
    .op_b         (op_b),
    .dest_reg     (dest_reg),
    .alu_result   (alu_result),
    .pc_to_reg    (pc_to_reg),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .mem_write    (mem_write),
    .load_sign    (load_sign),
    .dsize        (dsize),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_dest      (wb_dest),
    .wb_data      (wb_data),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: lane 0 is the most significant byte of the bus.
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << (3 - off));
    if (sz == 2'd1) return 4'(3 << (2 * (1 - off / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic [31:0] rd, input logic sgn);
    int off = int'(a % 4);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * (3 - off))) & 32'hFF;
      if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * (1 - off / 2))) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic m_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
`else
    return (sz == 2'd3) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic alu_op(input logic [31:0] alu, input logic [31:0] npc, input logic ptr,
                        input logic rw, input logic [4:0] d, input logic fl, input logic ack);
    logic v;
    @(negedge clk);
    in_valid = 1'b1; flush = fl; mem_to_reg = 1'b0; mem_write = 1'b0;
    alu_result = alu; next_pc = npc; pc_to_reg = ptr; reg_write = rw; dest_reg = d;
    dmem_ack = ack; dmem_rdata = $urandom;
    #1;
    v = !fl;
    chk1("alu_stall", stall, 1'b0);
    chk1("alu_req", dmem_req, 1'b0);
    chk1("alu_wb_valid", wb_valid, v);
    chk1("alu_wb_reg_write", wb_reg_write, v && rw);
    if (v) begin
      chk32("alu_wb_data", wb_data, ptr ? npc : alu);
      chk32("alu_wb_dest", 32'(wb_dest), 32'(d));
    end
  endtask

  task automatic mem_op(input logic [31:0] a, input logic [1:0] sz, input logic st,
                        input logic sg, input logic [31:0] b, input logic [31:0] rd,
                        input int ack_dly, input int flush_at, input logic [4:0] d,
                        input logic rw, output int stalls);
    logic [1:0] szn;
    logic timed_out, killed, v;
    szn = (sz == 2'd3) ? 2'd2 : sz;
    stalls = 0;
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b0; mem_to_reg = !st; mem_write = st; alu_result = a;
    op_b = b; dsize = sz; load_sign = sg; dest_reg = d; reg_write = rw; pc_to_reg = 1'b0;
    dmem_ack = 1'b0;
    #1;
    if (m_trap(szn, a)) begin
      chk1("trap_err", mem_err, 1'b1);
      chk1("trap_stall", stall, 1'b0);
      chk1("trap_wb_valid", wb_valid, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk1("trap_req", dmem_req, 1'b0);
      return;
    end
    chk1("issue_stall", stall, 1'b1);
    chk1("issue_wb_valid", wb_valid, 1'b0);
    chk1("issue_err", mem_err, 1'b0);
    if (stall) stalls++;
    timed_out = 1'b1;
    killed = 1'b0;
    for (int k = 0; k < int'(TO); k++) begin
      @(negedge clk);
      flush = (k == flush_at);
      dmem_ack = (k == ack_dly);
      dmem_rdata = (k == ack_dly) ? rd : $urandom;
      if (k == flush_at) killed = 1'b1;
      #1;
      chk1("wait_req", dmem_req, 1'b1);
      chk1("wait_stall", stall, 1'b1);
      if (stall) stalls++;
      if (k == 0) begin
        chk32("wait_addr", dmem_addr, a & 32'hFFFF_FFFC);
        chk32("wait_be", 32'(dmem_be), 32'(m_be(szn, a)));
        chk1("wait_we", dmem_we, st);
        if (st) chk32("wait_wdata", dmem_wdata, m_wdata(szn, b));
      end
      if (k == ack_dly) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(negedge clk);
    dmem_ack = 1'b0; flush = 1'b0; dmem_rdata = $urandom;
    #1;
    v = !timed_out && !killed;
    chk1("done_req", dmem_req, 1'b0);
    chk1("done_stall", stall, 1'b0);
    chk1("done_err", mem_err, timed_out);
    chk1("done_wb_valid", wb_valid, v);
    chk1("done_wb_reg_write", wb_reg_write, v && rw && !st);
    if (v && !st) chk32("done_wb_data", wb_data, m_load(szn, a, rd, sg));
    if (v) chk32("done_wb_dest", 32'(wb_dest), 32'(d));
  endtask

  initial begin
    int stalls;
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; pc_to_reg = 1'b0; reg_write = 1'b0;
    mem_to_reg = 1'b0; mem_write = 1'b0; load_sign = 1'b0; next_pc = '0; op_b = '0;
    alu_result = '0; dmem_rdata = '0; dest_reg = '0; dsize = '0; dmem_ack = 1'b0;
    #1;
    chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_we", dmem_we, 1'b0);
    chk32("rst_addr", dmem_addr, 32'h0);
    chk32("rst_be", 32'(dmem_be), 32'h0);
    chk32("rst_wdata", dmem_wdata, 32'h0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_err", mem_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    alu_op(32'h0000_1234, 32'h0000_0044, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    alu_op(32'h0000_5678, 32'h0000_0048, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    alu_op(32'hDEAD_0000, 32'h0000_004C, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    alu_op(32'h0000_0001, 32'h0000_0050, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1);

    mem_op(32'h103, 2'd0, 1'b0, 1'b1, 32'h0, 32'h1122_3380, 2, -1, 5'd7, 1'b1, stalls);
    chk32("lb_wb_data_const", wb_data, 32'hFFFF_FF80);
    chk32("lb_stall_cycles", 32'(stalls), 32'd4);

    mem_op(32'h102, 2'd1, 1'b1, 1'b0, 32'h0000_BEEF, 32'h0, 1, -1, 5'd8, 1'b1, stalls);
    mem_op(32'h200, 2'd2, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 99, -1, 5'd9, 1'b1, stalls);
    chk32("timeout_stall_cycles", 32'(stalls), 32'(1 + TO));
    mem_op(32'h204, 2'd2, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, 3, 1, 5'd10, 1'b1, stalls);
    mem_op(32'h101, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0BAD_BEEF, 0, -1, 5'd11, 1'b1, stalls);
    mem_op(32'h102, 2'd1, 1'b0, 1'b0, 32'h0, 32'h0102_8384, 0, -1, 5'd12, 1'b1, stalls);
    alu_op(32'h0000_00AA, 32'h0, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        alu_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end else begin
        mem_op($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 5)),
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1,
               5'($urandom), 1'($urandom_range(0, 1)), stalls);
      end
    end

    // Asynchronous reset while an access is outstanding.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b0; mem_to_reg = 1'b1; mem_write = 1'b0; dsize = 2'd2;
    alu_result = 32'h300; dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk1("midwait_req", dmem_req, 1'b1);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk1("async_rst_req", dmem_req, 1'b0);
    chk1("async_rst_stall", stall, 1'b0);
    chk32("async_rst_addr", dmem_addr, 32'h0);
    reset = 1'b1;
    alu_op(32'h0000_0777, 32'h0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
